pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Reset and lock supervisor for the fabric PLL. Runs on the PLL reference clock. It drives the PLL `rst` input, watches the PLL `locked` output, and releases the design-wide system reset only after lock has been continuously stable. It re-sequences on loss of lock or on request, and latches a failure flag after repeated lock timeouts.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 125000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 125 MHz).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release.
- `MAX_RETRIES`, 8: failed attempts before FAILED (1–15).

Ports:
- `refclk`, in, 1: 125 MHz reference clock; sole clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `pll_locked`, in, 1: PLL `locked`, asynchronous to `refclk`.
- `force_relock`, in, 1: synchronous single-cycle request to restart sequencing.
- `pll_rst`, out, 1: to PLL `rst`.
- `sys_rst`, out, 1: active-high system reset for downstream logic.
- `ready`, out, 1: high only in RUN.
- `fail`, out, 1: high only in FAILED.
- `retry_count`, out, 4: failed attempts since last RUN entry or relock request.
- `lock_loss_count`, out, 8: RUN→lock-loss events, saturating at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`lock_s`). Synchronizer flops reset to 0.
- States are PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAILED. Reset state is PLL_RESET with the cycle counter at 0.
- **PLL_RESET**: `pll_rst`=1. After `RST_HOLD_CYCLES` cycles → WAIT_LOCK, counter cleared.
- **WAIT_LOCK**: `pll_rst`=0.
  - `lock_s`=1 → STABILIZE, counter cleared.
  - Otherwise, at counter = `LOCK_TIMEOUT`−1, `retry_count` increments. If the new value equals `MAX_RETRIES` → FAILED; else → PLL_RESET.
- **STABILIZE**:
  - `lock_s`=0 → WAIT_LOCK with counter cleared. This does not count as a retry.
  - After `LOCK_STABLE_CYCLES` consecutive `lock_s`=1 cycles → RUN; `retry_count` clears.
- **RUN**: `sys_rst`=0, `ready`=1.
  - `lock_s`=0 → `lock_loss_count`+1 (saturating), then → PLL_RESET.
- **FAILED**: `pll_rst`=1, `sys_rst`=1, `fail`=1. The block holds here until `rst` or `force_relock`.
- `force_relock`=1 in any state → PLL_RESET, counter and `retry_count` cleared.
  - In RUN, if `lock_s`=0 in the same cycle, the loss is still counted.
- Only one shared cycle counter is used, sized for the largest parameter. It never wraps; it is cleared on every state change.
- Outside RUN, `sys_rst`=1 in every state.

## Timing
- Reset values: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `retry_count`=0, `lock_loss_count`=0.
- All outputs are registered Moore decodes. They are updated on the same edge as the state register, so each output is valid from the first cycle of its state.
- Sync latency: `pll_locked` edge → `lock_s` in 2 cycles (3 worst case).
- Minimum time from `rst` deassert to `ready`=1 is `RST_HOLD_CYCLES` + sync latency + `LOCK_STABLE_CYCLES` + 1 cycles.
- `pll_locked` falling in RUN → `sys_rst`=1 within 3 cycles.
- `rst` asserted mid-operation forces reset values immediately (asynchronously), including both counts.
- `rst` deassertion must be synchronized externally to `refclk`.

## Configuration
- `PLL_SEQ_LOSS_COUNT_EN`
  - Defined: `lock_loss_count` is implemented as described.
  - Undefined: the counter register is removed and `lock_loss_count` is tied to 8'd0. All state behaviour is unchanged.

## Test plan
Bench parameters for all scenarios: `RST_HOLD_CYCLES`=4, `LOCK_TIMEOUT`=100, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- **Nominal lock**: `pll_locked`=1 from 10 cycles after `rst` release → `pll_rst` high for exactly 4 cycles; `sys_rst` falls and `ready` rises after 8 stable `lock_s` cycles; `retry_count`=0.
- **Lock glitch in STABILIZE**: `pll_locked` drops for 1 cycle after 5 stable cycles → return to WAIT_LOCK; `ready` rises only after 8 new consecutive cycles; `retry_count` stays 0.
- **Timeout to FAILED**: `pll_locked` held 0 → two 4-cycle `pll_rst` pulses separated by 100 cycles; after the second timeout `fail`=1, `retry_count`=2, `pll_rst`=1, `sys_rst`=1 held.
- **Recover from FAILED**: `force_relock` pulse with `pll_locked`=1 → `fail`=0 next cycle; `retry_count`=0; `ready`=1 after the nominal sequence.
- **Lock loss in RUN**: drop `pll_locked` in RUN → `sys_rst`=1 within 3 cycles; `lock_loss_count`=1; PLL re-reset and relock. Repeat 300 times → count saturates at 255 (tied to 0 with the macro undefined).
- **Async reset mid-STABILIZE**: pulse `rst` → all outputs at reset values in the same cycle; sequencing restarts from PLL_RESET.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor: sequences the PLL reset, qualifies lock and gates the system reset.
// Optional feature macro: PLL_SEQ_LOSS_COUNT_EN (implements lock_loss_count; otherwise tied to 0).
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_TIMEOUT       = 125000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       HOLD_LAST    = cnt_t'(RST_HOLD_CYCLES - 1);
  localparam cnt_t       TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t       STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0] RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAILED
  } state_t;

  function automatic cnt_t cnt_sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

  state_t     state, state_nxt;
  cnt_t       cnt;
  logic       cnt_clr;
  logic [3:0] retry_nxt;
  logic       pll_rst_nxt, sys_rst_nxt, ready_nxt, fail_nxt;
  logic       sync_p0, lock_s;

  // Stage p0/p1: two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      lock_s  <= sync_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    retry_nxt = retry_count;
    if (force_relock) begin
      state_nxt = PLL_RESET;
      cnt_clr   = 1'b1;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_clr   = 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABILIZE;
            cnt_clr   = 1'b1;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nxt = retry_count + 4'd1;
            state_nxt = (retry_nxt == RETRY_LIMIT) ? FAILED : PLL_RESET;
            cnt_clr   = 1'b1;
          end
        end
        STABILIZE: begin
          // A single dropout restarts qualification but is not a failed attempt
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            cnt_clr   = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            cnt_clr   = 1'b1;
            retry_nxt = 4'd0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt = PLL_RESET;
            cnt_clr   = 1'b1;
          end
        end
        FAILED: begin
          state_nxt = FAILED;
        end
        default: begin
          state_nxt = PLL_RESET;
          cnt_clr   = 1'b1;
        end
      endcase
    end

    // Outputs decode the next state so they are registered alongside it
    pll_rst_nxt = (state_nxt == PLL_RESET) || (state_nxt == FAILED);
    sys_rst_nxt = (state_nxt != RUN);
    ready_nxt   = (state_nxt == RUN);
    fail_nxt    = (state_nxt == FAILED);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= PLL_RESET;
      cnt         <= '0;
      retry_count <= 4'd0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_clr ? '0 : cnt_sat_inc(cnt);
      retry_count <= retry_nxt;
      pll_rst     <= pll_rst_nxt;
      sys_rst     <= sys_rst_nxt;
      ready       <= ready_nxt;
      fail        <= fail_nxt;
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  function automatic logic [7:0] loss_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] loss_cnt;
  logic       loss_event;

  // Any RUN cycle without lock leaves RUN, with or without a coincident relock request
  assign loss_event = (state == RUN) && !lock_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= 8'd0;
    end else if (loss_event) begin
      loss_cnt <= loss_sat_inc(loss_cnt);
    end
  end

  assign lock_loss_count = loss_cnt;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule
